// File: rtl/project_types.sv
// project_types: shared register-file types and constants.
package project_types;
  localparam logic [4:0] REG_ADDR_ZERO = 5'd0;
  typedef logic [31:0] reg_data_t;
  typedef struct packed {
    logic       en;
    logic [4:0] addr;
  } reg_info_t;
endpackage

// File: rtl/i_regbus.sv
// i_regbus: two-port register read bus (requests in, data out).
interface i_regbus import project_types::*; ();
  reg_info_t r1_info;
  reg_info_t r2_info;
  reg_data_t r1_data;
  reg_data_t r2_data;
  modport slave (input r1_info, r2_info, output r1_data, r2_data);
  modport master (output r1_info, r2_info, input r1_data, r2_data);
endinterface

// File: rtl/reg_read_mux.sv
// reg_read_mux: one read port with reset/disable gating and write-back bypass.
module reg_read_mux import project_types::*; #(
  parameter bit FORWARD_EN = 1'b1,
  parameter int REG_COUNT  = 32
) (
  input  logic      rst,
  input  reg_info_t rd_info,
  input  reg_info_t wb_info,
  input  reg_data_t wb_data,
  input  reg_data_t arr_data,
  output reg_data_t rd_data
);
  logic valid;
  logic hit;
  always_comb begin
    valid   = rd_info.en && rd_info.addr != REG_ADDR_ZERO && int'(rd_info.addr) < REG_COUNT;
    hit     = FORWARD_EN && wb_info.en && wb_info.addr == rd_info.addr;
    rd_data = (rst || !valid) ? '0 : hit ? wb_data : arr_data;
  end
endmodule

// File: rtl/reg_file.sv
// reg_file: GPR array with x0 hardwired to zero and two combinational read ports.
module reg_file import project_types::*; #(
  parameter bit FORWARD_EN = 1'b1,
  parameter int REG_COUNT  = 32
) (
  input  logic      clk,
  input  logic      rst,
  i_regbus.slave    regbus,
  input  reg_info_t wb_info,
  input  reg_data_t wb_data
);
  reg_data_t regs [REG_COUNT];
  reg_data_t r1_arr;
  reg_data_t r2_arr;
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    else if (wb_info.en && wb_info.addr != REG_ADDR_ZERO && int'(wb_info.addr) < REG_COUNT)
      regs[wb_info.addr] <= wb_data;
  // Out-of-range array reads are masked to zero by the read mux.
  always_comb begin
    r1_arr = regs[regbus.r1_info.addr];
    r2_arr = regs[regbus.r2_info.addr];
  end
  reg_read_mux #(.FORWARD_EN(FORWARD_EN), .REG_COUNT(REG_COUNT)) u_rd1 (
    .rst(rst), .rd_info(regbus.r1_info), .wb_info(wb_info), .wb_data(wb_data),
    .arr_data(r1_arr), .rd_data(regbus.r1_data)
  );
  reg_read_mux #(.FORWARD_EN(FORWARD_EN), .REG_COUNT(REG_COUNT)) u_rd2 (
    .rst(rst), .rd_info(regbus.r2_info), .wb_info(wb_info), .wb_data(wb_data),
    .arr_data(r2_arr), .rd_data(regbus.r2_data)
  );
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter FORWARD_EN, default 1, enabling same-cycle write-to-read bypass.
REQ-002 SHALL have parameter REG_COUNT, default 32, giving the number of architectural GPRs; index width is 5 bits.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port regbus  i_regbus.slave  -  read requests in (r1_info, r2_info), read data out (r1_data, r2_data).
REQ-006 SHALL have port wb_info  input  reg_info_t  write-back request: en plus 5-bit addr.
REQ-007 SHALL have port wb_data  input  reg_data_t (32)  write-back data.

Function
REQ-008 SHALL hold REG_COUNT 32-bit registers; register 0 SHALL always read 0 and SHALL NOT be writable.
REQ-009 SHALL write wb_data into regs[wb_info.addr] at the rising clk edge when wb_info.en=1, wb_info.addr!=0 and rst=0.
REQ-010 SHALL produce each read port combinationally, with 0-cycle latency, from its reg_info_t request.
REQ-011 SHALL drive rN_data=0 when rst=1, when rN_info.en=0, or when rN_info.addr=0.
REQ-012 SHALL drive rN_data=wb_data when FORWARD_EN=1, wb_info.en=1, wb_info.addr=rN_info.addr and the address is nonzero (write-through bypass).
REQ-013 SHALL otherwise drive rN_data=regs[rN_info.addr].
REQ-014 SHALL drive rN_data=regs[addr] (old value) in the bypass case when FORWARD_EN=0.
REQ-015 SHALL resolve r1 and r2 independently, including both ports reading the same address, and both ports matching wb_info.addr simultaneously.
REQ-016 SHALL ignore writes to addresses >= REG_COUNT and SHALL return 0 for reads of them.
REQ-017 SHALL apply the priority rst > en=0 / addr=0 > bypass > array for read outputs.

Reset
REQ-018 SHALL clear all registers to 0 at the first rising clk edge with rst=1.
REQ-019 SHALL drop any write-back presented in a cycle with rst=1.
REQ-020 SHALL hold read outputs at 0 for the whole time rst=1, including when rst is asserted mid-operation.

Structure
REQ-021 SHALL take reg_info_t (struct: en, addr[4:0]) and reg_data_t (32-bit logic) from package project_types; REG_ADDR_ZERO SHALL be a package constant there.
REQ-022 SHALL be a single module; an internal read-port function or sub-module named reg_read_mux, instantiated twice, is allowed.
REQ-023 SHALL contain no latches; storage SHALL be one always_ff and read muxing SHALL be always_comb.

Verification
REQ-024 Bench SHALL cover: rst=1 for 1 cycle, then read r1 addr=5 en=1 -> r1_data=0.
REQ-025 Bench SHALL cover: write addr=3 data=0xDEADBEEF, next cycle r2 addr=3 en=1 -> r2_data=0xDEADBEEF.
REQ-026 Bench SHALL cover: same cycle wb addr=7 data=0x12345678 and r1 addr=7 -> r1_data=0x12345678 with FORWARD_EN=1; with FORWARD_EN=0 -> r1_data is the prior value.
REQ-027 Bench SHALL cover: write addr=0 data=0xFFFFFFFF, read r1/r2 addr=0 in the same and the next cycle -> 0.
REQ-028 Bench SHALL cover: regs[9]=0xA5A5A5A5, r1 addr=9 with en=0 -> r1_data=0; r2 addr=9 with en=1 -> r2_data=0xA5A5A5A5.
REQ-029 Bench SHALL cover: rst=1 in the same cycle as wb addr=4 data=0x1 -> regs[4]=0 afterward, and outputs stay 0 during reset.
